// File: rtl/ball_renderer_pkg.sv
// Shared types and constants for the ball renderer: motion directions,
// WASD keycodes and the output colours.
package ball_renderer_pkg;

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    // USB HID usage IDs for the steering keys
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [23:0] BALL_RGB  = 24'hFF5500;
    localparam logic [23:0] BG_RGB    = 24'h000040;
    localparam logic [23:0] BLANK_RGB = 24'h000000;

    // Unrecognised keys (including "no key") keep the current heading
    function automatic dir_t key_to_dir(input logic [7:0] key, input dir_t cur);
        dir_t d;
        d = cur;
        case (key)
            KEY_W:   d = UP;
            KEY_S:   d = DOWN;
            KEY_A:   d = LEFT;
            KEY_D:   d = RIGHT;
            default: d = cur;
        endcase
        return d;
    endfunction

    function automatic logic [23:0] pixel_rgb(input logic blank_n, input logic hit);
        logic [23:0] c;
        if (!blank_n)
            c = BLANK_RGB;
        else if (hit)
            c = BALL_RGB;
        else
            c = BG_RGB;
        return c;
    endfunction

endpackage

// File: rtl/ball_motion.sv
// Frame-tick detector, keyboard/bounce direction FSM and ball position
// registers; position advances once per vsync falling edge.
module ball_motion
    import ball_renderer_pkg::*;
#(
    parameter int BALL_SIZE = 4,
    parameter int STEP      = 1,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       vs_in,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic       frame_tick
);

    localparam logic [10:0] SZ   = 11'(BALL_SIZE);
    localparam logic [10:0] ST   = 11'(STEP);
    localparam logic [10:0] XMIN = 11'(X_MIN);
    localparam logic [10:0] XMAX = 11'(X_MAX);
    localparam logic [10:0] YMIN = 11'(Y_MIN);
    localparam logic [10:0] YMAX = 11'(Y_MAX);

    logic        r_vs_d;
    dir_t        r_dir;
    logic [9:0]  r_x;
    logic [9:0]  r_y;

    logic        w_tick;
    dir_t        w_dir_key;
    dir_t        w_dir_nxt;
    logic [9:0]  w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic [10:0] w_x11;
    logic [10:0] w_y11;

    // Gated by Reset_n so the pulse is held low while reset is asserted
    assign w_tick = r_vs_d & ~vs_in & Reset_n;
    assign w_x11  = {1'b0, r_x};
    assign w_y11  = {1'b0, r_y};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_d <= 1'b1;
            r_dir  <= STOP;
            r_x    <= 10'(X_CENTER);
            r_y    <= 10'(Y_CENTER);
        end else begin
            r_vs_d <= vs_in;
            r_dir  <= w_dir_nxt;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
        end
    end

    always_comb begin
        w_dir_key = key_to_dir(keycode, r_dir);
        w_dir_nxt = r_dir;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        if (w_tick) begin
            w_dir_nxt = w_dir_key;
            // Wall bounce overrides the key-selected heading
            case (w_dir_key)
                RIGHT:   if (w_x11 + SZ >= XMAX) w_dir_nxt = LEFT;
                LEFT:    if (w_x11 <= XMIN + SZ) w_dir_nxt = RIGHT;
                DOWN:    if (w_y11 + SZ >= YMAX) w_dir_nxt = UP;
                UP:      if (w_y11 <= YMIN + SZ) w_dir_nxt = DOWN;
                default: w_dir_nxt = w_dir_key;
            endcase
            case (w_dir_nxt)
                RIGHT:   w_x_nxt = 10'(w_x11 + ST);
                LEFT:    w_x_nxt = 10'(w_x11 - ST);
                DOWN:    w_y_nxt = 10'(w_y11 + ST);
                UP:      w_y_nxt = 10'(w_y11 - ST);
                default: w_x_nxt = r_x;
            endcase
        end
    end

    assign BallX      = r_x;
    assign BallY      = r_y;
    assign frame_tick = w_tick;

endmodule

// File: rtl/ball_renderer.sv
// Pixel-side renderer: two-stage pipeline from VGA coordinates to RGB with
// sync/blank delayed to stay aligned with the colour.
module ball_renderer
    import ball_renderer_pkg::*;
#(
    parameter int BALL_SIZE = 4,
    parameter int STEP      = 1,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_in,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       hs_out,
    output logic       vs_out,
    output logic       blank_out,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic       frame_tick
);

    localparam logic [21:0] R2 = 22'(BALL_SIZE * BALL_SIZE);

    logic [9:0]         w_ball_x;
    logic [9:0]         w_ball_y;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;

    logic signed [10:0] r_dx_p1;
    logic signed [10:0] r_dy_p1;
    logic               r_hs_p1;
    logic               r_vs_p1;
    logic               r_blank_p1;

    logic signed [21:0] w_dx_ext;
    logic signed [21:0] w_dy_ext;
    logic signed [21:0] w_dx_sq;
    logic signed [21:0] w_dy_sq;
    logic [21:0]        w_dist;
    logic               w_hit;
    logic [23:0]        w_rgb;

    logic [23:0]        r_rgb_p2;
    logic               r_hs_p2;
    logic               r_vs_p2;
    logic               r_blank_p2;

    ball_motion #(
        .BALL_SIZE (BALL_SIZE),
        .STEP      (STEP),
        .X_MIN     (X_MIN),
        .X_MAX     (X_MAX),
        .Y_MIN     (Y_MIN),
        .Y_MAX     (Y_MAX),
        .X_CENTER  (X_CENTER),
        .Y_CENTER  (Y_CENTER)
    ) u_motion (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .vs_in      (vs_in),
        .BallX      (w_ball_x),
        .BallY      (w_ball_y),
        .frame_tick (frame_tick)
    );

    assign w_dx = signed'({1'b0, DrawX}) - signed'({1'b0, w_ball_x});
    assign w_dy = signed'({1'b0, DrawY}) - signed'({1'b0, w_ball_y});

    // Stage 1: pixel offset from the ball centre
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dx_p1    <= '0;
            r_dy_p1    <= '0;
            r_hs_p1    <= 1'b0;
            r_vs_p1    <= 1'b0;
            r_blank_p1 <= 1'b0;
        end else begin
            r_dx_p1    <= w_dx;
            r_dy_p1    <= w_dy;
            r_hs_p1    <= hs_in;
            r_vs_p1    <= vs_in;
            r_blank_p1 <= blank_in;
        end
    end

    assign w_dx_ext = 22'(r_dx_p1);
    assign w_dy_ext = 22'(r_dy_p1);
    assign w_dx_sq  = w_dx_ext * w_dx_ext;
    assign w_dy_sq  = w_dy_ext * w_dy_ext;
    assign w_dist   = $unsigned(w_dx_sq) + $unsigned(w_dy_sq);
    assign w_hit    = (w_dist <= R2);
    assign w_rgb    = pixel_rgb(r_blank_p1, w_hit);

    // Stage 2: colour select, syncs re-aligned with the colour
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb_p2   <= BLANK_RGB;
            r_hs_p2    <= 1'b0;
            r_vs_p2    <= 1'b0;
            r_blank_p2 <= 1'b0;
        end else begin
            r_rgb_p2   <= w_rgb;
            r_hs_p2    <= r_hs_p1;
            r_vs_p2    <= r_vs_p1;
            r_blank_p2 <= r_blank_p1;
        end
    end

    assign Red       = r_rgb_p2[23:16];
    assign Green     = r_rgb_p2[15:8];
    assign Blue      = r_rgb_p2[7:0];
    assign hs_out    = r_hs_p2;
    assign vs_out    = r_vs_p2;
    assign blank_out = r_blank_p2;
    assign BallX     = w_ball_x;
    assign BallY     = w_ball_y;

endmodule

// File: tb/tb_ball_renderer.sv
// Scoreboard bench for ball_renderer: stimulus queues expected values tagged
// with the cycle they are due; a negedge monitor compares them.
module tb_ball_renderer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs_in;
    logic       vs_in;
    logic       blank_in;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic       hs_out;
    logic       vs_out;
    logic       blank_out;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic       frame_tick;

    ball_renderer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .blank_in   (blank_in),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .blank_out  (blank_out),
        .BallX      (BallX),
        .BallY      (BallY),
        .frame_tick (frame_tick)
    );

    always #20 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    localparam int K_PIX  = 0;
    localparam int K_BALL = 1;
    localparam int K_TICK = 2;
    localparam int K_RST  = 3;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] actual(input int kind);
        logic [63:0] a;
        case (kind)
            K_PIX:   a = 64'({hs_out, vs_out, blank_out, Red, Green, Blue});
            K_BALL:  a = 64'({BallX, BallY});
            K_TICK:  a = 64'(frame_tick);
            default: a = 64'({Red, Green, Blue, hs_out, vs_out, blank_out, BallX, BallY, frame_tick});
        endcase
        return a;
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            K_PIX:   return "pixel{hs,vs,blank,rgb}";
            K_BALL:  return "ball{x,y}";
            K_TICK:  return "frame_tick";
            default: return "reset_state";
        endcase
    endfunction

    always @(negedge Clk) begin
        logic [63:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                checks++;
                act = actual(q[i].kind);
                if (q[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s stale entry due=%0d at cycle %0d", kind_name(q[i].kind), q[i].due, cyc);
                end else if (act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d actual=%h expected=%h", kind_name(q[i].kind), cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [63:0] exp, input int delay);
        exp_t e;
        e.due  = cyc + delay;
        e.kind = kind;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic pixel(input int x, input int y, input logic hs, input logic blank,
                         input logic [23:0] rgb);
        DrawX    = x[9:0];
        DrawY    = y[9:0];
        hs_in    = hs;
        blank_in = blank;
        push(K_PIX, 64'({hs, 1'b1, blank, rgb}), 2);
        step();
    endtask

    // One vsync falling edge with key held only in the tick cycle
    task automatic frame(input logic [7:0] key, input int ex, input int ey);
        keycode = key;
        vs_in   = 1'b0;
        push(K_TICK, 64'd1, 0);
        step();
        vs_in   = 1'b1;
        keycode = 8'h04;
        push(K_TICK, 64'd0, 0);
        push(K_BALL, 64'({ex[9:0], ey[9:0]}), 0);
        step();
    endtask

    localparam logic [23:0] C_BALL = 24'hFF5500;
    localparam logic [23:0] C_BG   = 24'h000040;
    localparam logic [23:0] C_BLK  = 24'h000000;
    localparam logic [63:0] RST_EXP = 64'({24'h0, 3'b000, 10'd320, 10'd240, 1'b0});

    initial begin
        logic [7:0] keys [4];
        keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h07; keys[3] = 8'h04;

        Reset_n  = 1'b0;
        keycode  = 8'h00;
        DrawX    = 10'd320;
        DrawY    = 10'd240;
        hs_in    = 1'b1;
        vs_in    = 1'b1;
        blank_in = 1'b1;
        step();
        push(K_RST, RST_EXP, 0);
        step();
        Reset_n = 1'b1;
        step();
        push(K_TICK, 64'd0, 0);
        push(K_BALL, 64'({10'd320, 10'd240}), 0);
        step();
        frame(8'h00, 320, 240);

        pixel(320, 240, 1'b1, 1'b1, C_BALL);
        pixel(325, 240, 1'b0, 1'b1, C_BG);
        pixel(324, 240, 1'b1, 1'b1, C_BALL);
        pixel(316, 240, 1'b0, 1'b1, C_BALL);
        pixel(323, 243, 1'b1, 1'b1, C_BG);
        pixel(320, 245, 1'b1, 1'b1, C_BG);
        pixel(320, 236, 1'b0, 1'b1, C_BALL);
        pixel(320, 240, 1'b0, 1'b0, C_BLK);
        pixel(0,   0,   1'b1, 1'b1, C_BG);
        pixel(639, 479, 1'b1, 1'b1, C_BG);
        blank_in = 1'b1;
        hs_in    = 1'b1;
        step();
        step();

        frame(8'h07, 321, 240);
        frame(8'h07, 322, 240);
        frame(8'h07, 323, 240);
        frame(8'h00, 324, 240);
        frame(8'h00, 325, 240);
        frame(8'h1A, 325, 239);
        frame(8'h1A, 325, 238);
        for (int i = 1; i <= 234; i++) frame(8'h00, 325, 238 - i);
        frame(8'h1A, 325, 5);
        for (int i = 1; i <= 310; i++) frame(8'h07, 325 + i, 5);
        frame(8'h00, 634, 5);
        frame(8'h00, 633, 5);

        for (int i = 0; i < 8; i++) begin
            keycode = keys[i % 4];
            push(K_TICK, 64'd0, 0);
            push(K_BALL, 64'({10'd633, 10'd5}), 0);
            step();
        end
        keycode = 8'h00;
        vs_in   = 1'b0;
        push(K_TICK, 64'd1, 0);
        step();
        for (int i = 1; i < 1600; i++) begin
            if (i == 5) keycode = 8'h07;
            push(K_TICK, 64'd0, 0);
            if (i == 1 || i == 1599) push(K_BALL, 64'({10'd632, 10'd5}), 0);
            step();
        end
        vs_in = 1'b1;
        step();

        DrawX    = 10'd632;
        DrawY    = 10'd5;
        blank_in = 1'b1;
        step();
        step();
        Reset_n = 1'b0;
        push(K_RST, RST_EXP, 0);
        step();
        step();
        Reset_n = 1'b1;
        step();
        push(K_TICK, 64'd0, 0);
        step();
        frame(8'h00, 320, 240);
        pixel(320, 240, 1'b1, 1'b1, C_BALL);

        for (int i = 0; i < 4; i++) step();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
            errors += q.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
